// File: rtl/sap_prog_loader.sv
// rtl/sap_prog_loader.sv - programming-mode loader feeding the SAP CPU RAM from a word stream
//
// Purpose: accepts an alternating address/data word stream over a valid/ready
// handshake, holds the CPU in programming mode and issues one pr_write strobe
// per address/data pair. Reports completion, a saturating write count and a
// sticky error flag.
//
// Optional feature macro: PROG_CHECKSUM_EN
//   When defined, the final write is followed by a checksum word that must bring
//   the modulo-2**DATA_W sum of every address and data word of the session to 0.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   start          begin a load session (sampled only in IDLE)
//   abort          terminate the session at once and flag an error
//   in_valid       stream word valid
//   in_data        stream word (address or data) [DATA_W]
//   in_last        marks the final word of the stream
//   in_ready       loader can accept a word
//   pr_mode        CPU programming mode enable
//   pr_address     RAM write address [ADDR_W]
//   pr_data        RAM write data [DATA_W]
//   pr_write       one-cycle RAM write strobe
//   busy           session in progress
//   done           one-cycle completion pulse (success or error)
//   err            sticky error, cleared on the next accepted start
//   words_written  write strobes this session, saturating at 2**ADDR_W [ADDR_W+1]
module sap_prog_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              pr_mode,
  output logic [ADDR_W-1:0] pr_address,
  output logic [DATA_W-1:0] pr_data,
  output logic              pr_write,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_written
);

`ifdef PROG_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_t;
`endif

  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_t state, state_nxt;
  logic   xfer;
  logic   addr_hi_bad;
  logic   last_q;

  assign xfer = in_valid && in_ready;

  // Address words must leave the bits above the RAM address range clear.
  generate
    if (DATA_W > ADDR_W) begin : g_addr_hi
      assign addr_hi_bad = |in_data[DATA_W-1:ADDR_W];
    end else begin : g_addr_full
      assign addr_hi_bad = 1'b0;
    end
  endgenerate

`ifdef PROG_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;
  logic [DATA_W-1:0] chk_total;
  assign chk_total = sum_q + in_data;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // abort wins over a simultaneous handshake in every session state.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    pr_mode   = 1'b0;
    busy      = 1'b0;
    pr_write  = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_ADDR;
      end
      S_ADDR: begin
        in_ready = 1'b1;
        pr_mode  = 1'b1;
        busy     = 1'b1;
        if (abort) begin
          state_nxt = S_ERR;
        end else if (xfer) begin
          state_nxt = (addr_hi_bad || in_last) ? S_ERR : S_DATA;
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        pr_mode  = 1'b1;
        busy     = 1'b1;
        if (abort) begin
          state_nxt = S_ERR;
        end else if (xfer) begin
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        pr_mode = 1'b1;
        busy    = 1'b1;
        if (abort) begin
          state_nxt = S_ERR;
        end else begin
          pr_write = 1'b1;
`ifdef PROG_CHECKSUM_EN
          state_nxt = last_q ? S_CHK : S_ADDR;
`else
          state_nxt = last_q ? S_DONE : S_ADDR;
`endif
        end
      end
`ifdef PROG_CHECKSUM_EN
      S_CHK: begin
        in_ready = 1'b1;
        pr_mode  = 1'b1;
        busy     = 1'b1;
        if (abort) begin
          state_nxt = S_ERR;
        end else if (xfer) begin
          state_nxt = (chk_total == '0) ? S_DONE : S_ERR;
        end
      end
`endif
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      S_ERR: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pr_address    <= '0;
      pr_data       <= '0;
      last_q        <= 1'b0;
      words_written <= '0;
      err           <= 1'b0;
`ifdef PROG_CHECKSUM_EN
      sum_q         <= '0;
`endif
    end else begin
      if (state == S_IDLE && start) begin
        err           <= 1'b0;
        words_written <= '0;
        last_q        <= 1'b0;
`ifdef PROG_CHECKSUM_EN
        sum_q         <= '0;
`endif
      end
      if (state == S_ADDR && xfer && !abort) begin
        pr_address <= in_data[ADDR_W-1:0];
`ifdef PROG_CHECKSUM_EN
        sum_q      <= sum_q + in_data;
`endif
      end
      if (state == S_DATA && xfer && !abort) begin
        pr_data <= in_data;
        last_q  <= in_last;
`ifdef PROG_CHECKSUM_EN
        sum_q   <= sum_q + in_data;
`endif
      end
      if (pr_write && words_written != CNT_MAX) begin
        words_written <= words_written + 1'b1;
      end
      // Set on the edge into ERR so err is already high during the ERR cycle.
      if (state_nxt == S_ERR) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sap_prog_loader.sv
// tb/tb_sap_prog_loader.sv - table-driven bench for sap_prog_loader (ADDR_W=4, DATA_W=8)
module tb_sap_prog_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       in_ready, pr_mode, pr_write, busy, done, err;
  logic [3:0] pr_address;
  logic [7:0] pr_data;
  logic [4:0] words_written;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  sap_prog_loader #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .pr_mode(pr_mode), .pr_address(pr_address),
    .pr_data(pr_data), .pr_write(pr_write), .busy(busy), .done(done),
    .err(err), .words_written(words_written)
  );

  typedef struct {
    logic        st;
    logic        ab;
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic [22:0] exp;
  } vec_t;

  vec_t vt[64];
  int   nv = 0;
  logic [7:0] words[$];

  // Packed output vector: ready,mode,write,addr,data,busy,done,err,count
  function automatic logic [22:0] e(input logic rdy, input logic md, input logic wr,
                                    input logic [3:0] a, input logic [7:0] dd,
                                    input logic bs, input logic dn, input logic er,
                                    input logic [4:0] ww);
    return {rdy, md, wr, a, dd, bs, dn, er, ww};
  endfunction

  function automatic logic [22:0] outs();
    return {in_ready, pr_mode, pr_write, pr_address, pr_data, busy, done, err, words_written};
  endfunction

  task automatic add(input logic st, input logic ab, input logic v, input logic [7:0] d,
                     input logic l, input logic [22:0] exp);
    vt[nv] = '{st, ab, v, d, l, exp};
    nv++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_stream(input bit toggle, output int strobes, output bit saw_done,
                            output bit saw_err);
    logic [7:0] seq[$];
    logic [7:0] sum;
    int idx, cyc, nw;
    bit xfer;
    seq = words;
    sum = 8'h00;
    foreach (words[i]) sum = sum + words[i];
`ifdef PROG_CHECKSUM_EN
    seq.push_back(8'h00 - sum);
`endif
    nw = seq.size();
    strobes = 0; saw_done = 0; saw_err = 0; idx = 0; cyc = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!saw_done && cyc < 400) begin
      in_valid = (idx < nw) && (!toggle || (cyc % 2 == 0));
      in_data  = (idx < nw) ? seq[idx] : 8'h00;
      in_last  = (idx == words.size() - 1);
      xfer = in_valid && in_ready;
      @(posedge clk); #1;
      if (xfer) idx++;
      if (pr_write) begin
        if (2 * strobes + 1 < words.size())
          chk($sformatf("strobe%0d", strobes), {20'h0, pr_address, pr_data},
              {20'h0, words[2*strobes][3:0], words[2*strobes+1]});
        else
          chk("extra_strobe", 32'd1, 32'd0);
        strobes++;
      end
      if (done) begin
        saw_done = 1;
        saw_err  = err;
      end
      cyc++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!saw_done) chk("stream_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int strobes;
    bit sd, se;

    // Reset held with active inputs
    start = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold", {9'h0, outs()}, 32'h0);
    start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_idle", {9'h0, outs()}, 32'h0);

    // st ab v data last | rdy md wr addr data busy done err ww
    add(0,1,0,8'h00,0, e(0,0,0,4'h0,8'h00,0,0,0,0));
    add(1,0,0,8'h00,0, e(1,1,0,4'h0,8'h00,1,0,0,0));
    add(0,0,1,8'h03,0, e(1,1,0,4'h3,8'h00,1,0,0,0));
    add(0,0,1,8'hA5,1, e(0,1,1,4'h3,8'hA5,1,0,0,0));
`ifdef PROG_CHECKSUM_EN
    add(0,0,0,8'h00,0, e(1,1,0,4'h3,8'hA5,1,0,0,1));
    add(0,0,1,8'h58,0, e(0,0,0,4'h3,8'hA5,0,1,0,1));
`else
    add(0,0,0,8'h00,0, e(0,0,0,4'h3,8'hA5,0,1,0,1));
`endif
    add(0,0,0,8'h00,0, e(0,0,0,4'h3,8'hA5,0,0,0,1));
    // address out of range
    add(1,0,0,8'h00,0, e(1,1,0,4'h3,8'hA5,1,0,0,0));
    add(0,0,1,8'h13,0, e(0,0,0,4'h3,8'hA5,0,1,1,0));
    add(0,0,0,8'h00,0, e(0,0,0,4'h3,8'hA5,0,0,1,0));
    // odd stream
    add(1,0,0,8'h00,0, e(1,1,0,4'h3,8'hA5,1,0,0,0));
    add(0,0,1,8'h05,1, e(0,0,0,4'h5,8'hA5,0,1,1,0));
    add(0,0,0,8'h00,0, e(0,0,0,4'h5,8'hA5,0,0,1,0));
    // abort in DATA with a word offered
    add(1,0,0,8'h00,0, e(1,1,0,4'h5,8'hA5,1,0,0,0));
    add(0,0,1,8'h07,0, e(1,1,0,4'h7,8'hA5,1,0,0,0));
    add(0,1,1,8'h55,1, e(0,0,0,4'h7,8'hA5,0,1,1,0));
    add(0,0,0,8'h00,0, e(0,0,0,4'h7,8'hA5,0,0,1,0));
    // start ignored while busy, abort in WRITE
    add(1,0,0,8'h00,0, e(1,1,0,4'h7,8'hA5,1,0,0,0));
    add(1,0,1,8'h02,0, e(1,1,0,4'h2,8'hA5,1,0,0,0));
    add(0,0,1,8'h33,0, e(0,1,1,4'h2,8'h33,1,0,0,0));
    add(0,1,0,8'h00,0, e(0,0,0,4'h2,8'h33,0,1,1,0));
    add(0,0,0,8'h00,0, e(0,0,0,4'h2,8'h33,0,0,1,0));
`ifdef PROG_CHECKSUM_EN
    // checksum match then mismatch
    add(1,0,0,8'h00,0, e(1,1,0,4'h2,8'h33,1,0,0,0));
    add(0,0,1,8'h01,0, e(1,1,0,4'h1,8'h33,1,0,0,0));
    add(0,0,1,8'h10,1, e(0,1,1,4'h1,8'h10,1,0,0,0));
    add(0,0,0,8'h00,0, e(1,1,0,4'h1,8'h10,1,0,0,1));
    add(0,0,1,8'hEF,0, e(0,0,0,4'h1,8'h10,0,1,0,1));
    add(0,0,0,8'h00,0, e(0,0,0,4'h1,8'h10,0,0,0,1));
    add(1,0,0,8'h00,0, e(1,1,0,4'h1,8'h10,1,0,0,0));
    add(0,0,1,8'h01,0, e(1,1,0,4'h1,8'h10,1,0,0,0));
    add(0,0,1,8'h10,1, e(0,1,1,4'h1,8'h10,1,0,0,0));
    add(0,0,0,8'h00,0, e(1,1,0,4'h1,8'h10,1,0,0,1));
    add(0,0,1,8'hEE,0, e(0,0,0,4'h1,8'h10,0,1,1,1));
    add(0,0,0,8'h00,0, e(0,0,0,4'h1,8'h10,0,0,1,1));
`endif

    for (int i = 0; i < nv; i++) begin
      start = vt[i].st; abort = vt[i].ab; in_valid = vt[i].v;
      in_data = vt[i].d; in_last = vt[i].l;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), {9'h0, outs()}, {9'h0, vt[i].exp});
    end
    start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    @(posedge clk); #1;

    // Twelve words, valid toggling, addresses 0,2,4.. data 0,10,20..
    words.delete();
    for (int k = 0; k < 6; k++) begin
      words.push_back(8'(2 * k));
      words.push_back(8'(10 * k));
    end
    run_stream(1'b1, strobes, sd, se);
    chk("twelve_strobes", strobes, 6);
    chk("twelve_count", {27'h0, words_written}, 6);
    chk("twelve_err", {31'h0, se}, 0);

    // 17 writes to one address: duplicate addresses and counter saturation
    words.delete();
    for (int k = 0; k < 17; k++) begin
      words.push_back(8'h0F);
      words.push_back(8'(k * 3 + 1));
    end
    run_stream(1'b0, strobes, sd, se);
    chk("sat_strobes", strobes, 17);
    chk("sat_count", {27'h0, words_written}, 16);
    chk("sat_last_write", {20'h0, pr_address, pr_data}, {20'h0, 4'hF, 8'd49});
    chk("sat_err", {31'h0, se}, 0);

    // Reset mid-session
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = 8'h04;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mid_in_data", {9'h0, outs()}, {9'h0, e(1,1,0,4'h4,8'd49,1,0,0,0)});
    rst = 1'b0;
    #1;
    chk("mid_reset", {9'h0, outs()}, 32'h0);
    @(posedge clk); #1;
    chk("mid_reset_nodone", {31'h0, done}, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/sap_prog_loader.md
Name: sap_prog_loader

Overview:
Parametrised programming-mode loader for the SAP CPU RAM, generalising the fixed 4-bit-address / 8-bit-data pr_mode/pr_address/pr_data interface.
- Accepts a valid/ready word stream of alternating address and data words.
- Holds the CPU in programming mode and issues one write strobe per pair.
- Reports completion, write count and stream errors.
- Sits between the host/UART front end and the cpu instance's programming ports.

Parameters:
ADDR_W, 4, RAM address width; RAM depth is 2**ADDR_W.
DATA_W, 8, stream word and RAM data width; must be >= ADDR_W.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
start  input  1  begin a load session; sampled only in IDLE
abort  input  1  terminate session immediately, flags error
in_valid  input  1  stream word valid
in_data  input  DATA_W  stream word (address or data)
in_last  input  1  marks final word of stream
in_ready  output  1  loader can accept word
pr_mode  output  1  CPU programming mode enable
pr_address  output  ADDR_W  RAM write address
pr_data  output  DATA_W  RAM write data
pr_write  output  1  one-cycle RAM write strobe
busy  output  1  session in progress
done  output  1  one-cycle completion pulse
err  output  1  sticky error; cleared on next accepted start
words_written  output  ADDR_W+1  count of write strobes this session, saturates at 2**ADDR_W

Behaviour:
- Reset (rst low, async): state IDLE; every output is 0, including the counter, err, pr_address and pr_data.
- Handshake: a word transfers on the rising edge where in_valid && in_ready. in_ready is 1 only in ADDR and DATA.
- States:
  - IDLE -> ADDR on start. The same edge clears err and words_written and sets pr_mode and busy.
  - ADDR: on transfer, latch in_data[ADDR_W-1:0] into pr_address.
    - Nonzero in_data[DATA_W-1:ADDR_W] -> ERR.
    - in_last on an address word -> ERR (odd stream).
    - Otherwise -> DATA.
  - DATA: on transfer, latch in_data into pr_data and record in_last -> WRITE.
  - WRITE: one cycle. pr_write=1, with pr_address/pr_data already stable since the previous edge. Increment words_written (saturating). Next state is DONE if last was recorded, else ADDR.
  - DONE: one cycle. done=1, pr_mode=0, busy=0 -> IDLE.
  - ERR: one cycle. err=1 (sticky), done=1, pr_mode=0, busy=0 -> IDLE.
- Latency: minimum 3 cycles per address/data pair (ADDR, DATA, WRITE), plus 1 cycle for DONE.
- pr_mode=1 and busy=1 in ADDR, DATA, WRITE (and CHK when compiled in).
- pr_address/pr_data hold their last values after a session ends.
- abort in any non-IDLE state takes priority over a simultaneous handshake -> ERR; no pr_write in that cycle. abort in IDLE is ignored.
- start while not in IDLE is ignored.
- Duplicate addresses are legal: each pair produces its own strobe, so the last write wins.
- The counter saturates at 2**ADDR_W and writes continue.
- Reset mid-session aborts at once: no done pulse, outputs return to 0.

Optional Feature:
PROG_CHECKSUM_EN.
- When defined: after the DATA word carrying in_last and its WRITE, the loader enters CHK instead of DONE, with in_ready=1. CHK accepts one checksum word.
  - Match: the checksum word plus the modulo-2**DATA_W sum of all address and data words this session equals 0 -> DONE.
  - Mismatch -> ERR.
  - The running sum is cleared on start.
- When undefined: no CHK state, no sum register; the last WRITE goes directly to DONE.

Test Plan:
- Reset: hold rst=0 with in_valid=1 and start=1 -> all outputs 0; release, idle -> still 0, in_ready=0.
- Basic load (ADDR_W=4, DATA_W=8): start, then stream 0x03, 0xA5(last) -> one pr_write with pr_address=3 and pr_data=0xA5; done one cycle later; words_written=1; pr_mode low after done.
- Twelve-word stream alternating addresses 0,2,4,... with data i*10 and in_valid toggling every other cycle -> 6 strobes in order, words_written=6, no err.
- Address range: address word 0x13 -> err=1, done pulse, no pr_write; the next start clears err.
- Odd stream and abort: in_last on address word 0x05 -> err; separately, abort asserted in DATA together with in_valid -> err, no strobe, pr_mode=0 the following cycle.
- PROG_CHECKSUM_EN: stream 0x01, 0x10(last), checksum 0xEF -> done, err=0; with checksum 0xEE -> err=1.
